// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 4-digit multiplexed 7-segment display driver.
//   scan_idx_t : digit scan index, 0 = rightmost digit, 3 = leftmost digit
//   SEG_BLANK  : logical segment pattern with every segment off
//   SEG_DASH   : logical pattern shown for the non-BCD codes 10..15
//   SEG_TABLE  : 16-entry code-to-segment lookup in logical polarity.
//                Bit order is {g,f,e,d,c,b,a}, and 1 means the segment is lit.
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [1:0] scan_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'b000_0000;
    localparam logic [6:0] SEG_DASH  = 7'b100_0000;

    // Entry 15 is the most significant element, so the list runs 15 down to 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_DASH,      // 15
        SEG_DASH,      // 14
        SEG_DASH,      // 13
        SEG_DASH,      // 12
        SEG_DASH,      // 11
        SEG_DASH,      // 10
        7'b110_1111,   // 9
        7'b111_1111,   // 8
        7'b000_0111,   // 7
        7'b111_1101,   // 6
        7'b110_1101,   // 5
        7'b110_0110,   // 4
        7'b100_1111,   // 3
        7'b101_1011,   // 2
        7'b000_0110,   // 1
        7'b011_1111    // 0
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD-to-segment decoder. The output is in logical polarity.
//   code_i : 4-bit digit code. Codes 10..15 decode to a dash.
//   seg_o  : segment pattern {g,f,e,d,c,b,a}, where 1 means lit.
// -----------------------------------------------------------------------------
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[code_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed 4-digit 7-segment display driver.
//
// A load strobe captures the four BCD digits into a shadow register. The shadow
// register is copied into the display register only when the scan wraps from
// digit 3 to digit 0. As a result, each frame always shows one consistent
// snapshot.
//
// Parameters
//   SCAN_DIV   : number of clock cycles each digit stays lit (2 .. 2**20)
//   DP_POS     : scan index whose decimal point is lit
//   ACTIVE_LOW : when nonzero, an, seg and dp are driven low-active
//
// Ports
//   clk                 : system clock
//   rst                 : asynchronous, active-high reset
//   load                : one-cycle strobe that samples the digit inputs
//   ones                : BCD digit for scan index 3 (leftmost)
//   tenths              : BCD digit for scan index 2
//   hundreths           : BCD digit for scan index 1
//   thousandths         : BCD digit for scan index 0 (rightmost)
//   an[3:0]             : digit enables. an[i] selects scan index i.
//   seg[6:0]            : segments {g,f,e,d,c,b,a}
//   dp                  : decimal point
//   frame               : one-cycle pulse when the scan wraps from 3 to 0
//
// Build option
//   SEG7_LZ_BLANK_EN : when defined, leading-zero blanking is enabled.
//                      A digit at an index above DP_POS is blanked when that
//                      digit and every higher digit are zero.
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int DP_POS     = 3,
    parameter int ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] ones,
    input  logic [3:0] tenths,
    input  logic [3:0] hundreths,
    input  logic [3:0] thousandths,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame
);

    localparam int            PW       = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);
    localparam scan_idx_t     DP_IDX   = scan_idx_t'(DP_POS);
    localparam logic          POL_INV  = (ACTIVE_LOW != 0);

    // "Off" levels at the pins for each output group.
    localparam logic [3:0]    AN_OFF   = {4{POL_INV}};
    localparam logic [6:0]    SEG_OFF  = {7{POL_INV}};

    // ---------------------------------------------------------------- state
    logic [15:0]   shadow_q,  shadow_d;
    logic          pending_q, pending_d;
    logic [15:0]   disp_q,    disp_d;
    logic [PW-1:0] pcnt_q,    pcnt_d;
    scan_idx_t     idx_q,     idx_d;
    logic [3:0]    an_q,      an_d;
    logic [6:0]    seg_q,     seg_d;
    logic          dp_q,      dp_d;
    logic          frame_q,   frame_d;

    logic          pcnt_wrap;
    logic          frame_wrap;
    logic [15:0]   sample;

    assign pcnt_wrap  = (pcnt_q == PCNT_MAX);
    assign frame_wrap = pcnt_wrap && (idx_q == 2'd3);
    assign sample     = {ones, tenths, hundreths, thousandths};

    // ------------------------------------------------------- digit select
    logic [3:0] digit [4];
    logic [3:0] cur_digit;
    logic [6:0] seg_logic;
    logic       blank;

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        assign digit[gi] = disp_q[gi*4 +: 4];
    end

    assign cur_digit = digit[idx_q];

    bcd_to_seg7 u_dec (
        .code_i (cur_digit),
        .seg_o  (seg_logic)
    );

`ifdef SEG7_LZ_BLANK_EN
    // lz_chain[i] is set when digit i and every digit above it are zero.
    // Index 0 is never blanked because DP_POS is always at least 0, so the
    // chain does not need an entry for index 0.
    logic [3:1] lz_chain;
    logic [3:0] blank_en;

    assign lz_chain[3] = (digit[3] == 4'd0);
    for (genvar gi = 1; gi < 3; gi++) begin : g_lz
        assign lz_chain[gi] = lz_chain[gi+1] && (digit[gi] == 4'd0);
    end

    // The position of DP_POS is fixed when the design is built. Because of
    // this, the decision of which indices may blank is made here at elaboration
    // time.
    for (genvar gi = 0; gi < 4; gi++) begin : g_blank
        if (gi > DP_POS) begin : g_on
            assign blank_en[gi] = lz_chain[gi];
        end else begin : g_off
            assign blank_en[gi] = 1'b0;
        end
    end

    assign blank = blank_en[idx_q];
`else
    assign blank = 1'b0;
`endif

    // ----------------------------------------------------------- next state
    always_comb begin
        pcnt_d    = pcnt_wrap ? '0 : pcnt_q + 1'b1;
        idx_d     = pcnt_wrap ? idx_q + 2'd1 : idx_q;

        // On a load that coincides with a frame boundary, the transfer uses
        // the old shadow value. The new sample remains pending for the next
        // frame.
        shadow_d  = load ? sample : shadow_q;
        disp_d    = (frame_wrap && pending_q) ? shadow_q : disp_q;
        pending_d = load ? 1'b1 : (frame_wrap ? 1'b0 : pending_q);

        // The pin outputs reflect the current idx and disp values, one cycle
        // later.
        an_d      = (4'b0001 << idx_q) ^ AN_OFF;
        seg_d     = (blank ? SEG_BLANK : seg_logic) ^ SEG_OFF;
        dp_d      = ((idx_q == DP_IDX) && !blank) ^ POL_INV;
        frame_d   = frame_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q  <= '0;
            pending_q <= 1'b0;
            disp_q    <= '0;
            pcnt_q    <= '0;
            idx_q     <= '0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_OFF;
            dp_q      <= POL_INV;
            frame_q   <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            disp_q    <= disp_d;
            pcnt_q    <= pcnt_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            frame_q   <= frame_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign dp    = dp_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Self-checking bench for seg7_scan_driver.
//   dut  : SCAN_DIV=4, DP_POS=3. Used for reset, load and transfer tests,
//          double and coincident loads, and the invalid code.
//   dut2 : SCAN_DIV=5, DP_POS=0. Used for dwell and frame period, and for
//          leading-zero blanking when SEG7_LZ_BLANK_EN is defined.
// Expected frame patterns are pushed into a queue when loads are driven. Each
// pattern is popped when the DUT scans the matching frame.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int D   = 4;
    localparam int D2  = 5;
    localparam int FR  = 4 * D;
    localparam int FR2 = 4 * D2;

    typedef logic [3:0][6:0] segs_t;   // element i = pin pattern shown at scan index i
    typedef struct packed {
        logic [15:0] digits;           // {ones, tenths, hundreths, thousandths}
        segs_t       segs;             // expected active-low seg per scan index
    } vec_t;

    localparam segs_t ZERO_SEGS = {4{7'b1000000}};

    logic       clk = 1'b0;
    logic       rst;
    logic       load, load2;
    logic [3:0] ones, tenths, hund, thou;
    logic [3:0] ones2, tenths2, hund2, thou2;
    logic [3:0] an, an2;
    logic [6:0] seg, seg2;
    logic       dp, dp2, frame, frame2;

    int checks = 0;
    int errors = 0;

    vec_t  vecs  [6];
    vec_t  vecs2 [2];
    segs_t exp_q [$];
    segs_t shadow_m;
    bit    pend_m;
    int    frame_no = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.SCAN_DIV(D), .DP_POS(3), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .load(load),
        .ones(ones), .tenths(tenths), .hundreths(hund), .thousandths(thou),
        .an(an), .seg(seg), .dp(dp), .frame(frame)
    );

    seg7_scan_driver #(.SCAN_DIV(D2), .DP_POS(0), .ACTIVE_LOW(1)) dut2 (
        .clk(clk), .rst(rst), .load(load2),
        .ones(ones2), .tenths(tenths2), .hundreths(hund2), .thousandths(thou2),
        .an(an2), .seg(seg2), .dp(dp2), .frame(frame2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic sync_frame();
        int n = 0;
        do begin @(negedge clk); n++; end while (frame !== 1'b1 && n < 8 * FR);
        check("sync_frame", {31'd0, frame}, 32'd1);
    endtask

    task automatic sync_frame2();
        int n = 0;
        do begin @(negedge clk); n++; end while (frame2 !== 1'b1 && n < 8 * FR2);
        check("sync_frame2", {31'd0, frame2}, 32'd1);
    endtask

    // This task scans one frame of dut, starting just after a frame pulse.
    // Loads are driven after sample ka and after sample kb. A value of -1 means
    // no load. A load after sample FR-2 coincides with the frame boundary.
    task automatic observe(input int ka, input vec_t va, input int kb, input vec_t vb);
        segs_t      cur, nxt, coinc;
        bit         has_coinc = 1'b0;
        vec_t       v;
        int         di;
        logic [3:0] an_exp;
        logic       dp_exp;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL exp_q: actual=empty required=entry at %0t", $time);
            cur = ZERO_SEGS;
        end else begin
            cur = exp_q.pop_front();
        end
        for (int k = 0; k < FR; k++) begin
            @(negedge clk);
            di     = k / D;
            an_exp = ~(4'b0001 << di);
            dp_exp = (di != 3);
            check("an", {28'd0, an}, {28'd0, an_exp});
            check("seg", {25'd0, seg}, {25'd0, cur[di]});
            check("dp", {31'd0, dp}, {31'd0, dp_exp});
            check("frame", {31'd0, frame}, {31'd0, (k == FR - 1)});
            load = 1'b0;
            if (k == ka || k == kb) begin
                v = (k == ka) ? va : vb;
                {ones, tenths, hund, thou} = v.digits;
                load = 1'b1;
                if (k == FR - 2) begin
                    has_coinc = 1'b1;
                    coinc     = v.segs;
                end else begin
                    shadow_m = v.segs;
                    pend_m   = 1'b1;
                end
            end
        end
        load = 1'b0;
        if (pend_m) begin
            nxt    = shadow_m;
            pend_m = 1'b0;
        end else begin
            nxt = cur;
        end
        if (has_coinc) begin
            shadow_m = coinc;
            pend_m   = 1'b1;
        end
        exp_q.push_back(nxt);
        frame_no++;
        $display("frame %0d: expected seg3..0 = %b %b %b %b, loads at %0d/%0d",
                 frame_no, cur[3], cur[2], cur[1], cur[0], ka, kb);
    endtask

    // This task scans one frame of dut2. It checks dwell time, the frame
    // period, the segment patterns, and that the decimal point is at index 0.
    task automatic observe2(input bit do_load, input vec_t v, input segs_t cur);
        int         di;
        logic [3:0] an_exp;
        logic       dp_exp;
        for (int k = 0; k < FR2; k++) begin
            @(negedge clk);
            di     = k / D2;
            an_exp = ~(4'b0001 << di);
            dp_exp = (di != 0);
            check("an2_dwell", {28'd0, an2}, {28'd0, an_exp});
            check("seg2", {25'd0, seg2}, {25'd0, cur[di]});
            check("dp2", {31'd0, dp2}, {31'd0, dp_exp});
            check("frame2_period", {31'd0, frame2}, {31'd0, (k == FR2 - 1)});
            load2 = 1'b0;
            if (do_load && k == 0) begin
                {ones2, tenths2, hund2, thou2} = v.digits;
                load2 = 1'b1;
            end
        end
        load2 = 1'b0;
        $display("dut2 frame: expected seg3..0 = %b %b %b %b", cur[3], cur[2], cur[1], cur[0]);
    endtask

    initial begin
        // digits, then expected active-low pins for scan index 3..0
        vecs[0] = '{16'h1234, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        vecs[1] = '{16'h5678, {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}};
        vecs[2] = '{16'h9999, {4{7'b0010000}}};
        vecs[3] = '{16'h005C, {7'b1000000, 7'b1000000, 7'b0010010, 7'b0111111}};
        vecs[4] = '{16'hFA09, {7'b0111111, 7'b0111111, 7'b1000000, 7'b0010000}};
        vecs[5] = '{16'h4321, {7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001}};
`ifdef SEG7_LZ_BLANK_EN
        vecs2[0] = '{16'h0047, {7'b1111111, 7'b1111111, 7'b0011001, 7'b1111000}};
        vecs2[1] = '{16'h0000, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
`else
        vecs2[0] = '{16'h0047, {7'b1000000, 7'b1000000, 7'b0011001, 7'b1111000}};
        vecs2[1] = '{16'h0000, {4{7'b1000000}}};
`endif

        rst   = 1'b1;
        load  = 1'b0; load2 = 1'b0;
        {ones, tenths, hund, thou}     = 16'h0000;
        {ones2, tenths2, hund2, thou2} = 16'h0000;
        pend_m = 1'b0;

        // Reset state, then the first edge after release shows index 0 = "0".
        #12;
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_dp", {31'd0, dp}, 32'd1);
        check("rst_frame", {31'd0, frame}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("first_an", {28'd0, an}, 32'b1110);
        check("first_seg", {25'd0, seg}, 32'b1000000);

        // Load, then transfer at the frame boundary. Double load, coincident
        // load, and invalid codes.
        sync_frame();
        exp_q.push_back(ZERO_SEGS);
        observe(0, vecs[0], -1, vecs[0]);      // still shows 0.000
        observe(-1, vecs[0], -1, vecs[0]);     // shows 1.234
        observe(1, vecs[1], 9, vecs[2]);       // 5678 is superseded by 9999
        observe(-1, vecs[0], -1, vecs[0]);     // shows 9999
        observe(FR - 2, vecs[3], -1, vecs[0]); // coincident load
        observe(-1, vecs[0], -1, vecs[0]);     // still 9999
        observe(5, vecs[4], FR - 2, vecs[5]);  // shows 005C (dash)
        observe(-1, vecs[0], -1, vecs[0]);     // shows dashes
        observe(-1, vecs[0], -1, vecs[0]);     // shows 4321

        // Assert reset mid-frame while a load is still pending.
        @(negedge clk);
        {ones, tenths, hund, thou} = vecs[1].digits;
        load = 1'b1;
        @(negedge clk); load = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_an", {28'd0, an}, 32'hF);
        check("midrst_seg", {25'd0, seg}, 32'h7F);
        check("midrst_dp", {31'd0, dp}, 32'd1);
        check("midrst_frame", {31'd0, frame}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("rel_an", {28'd0, an}, 32'b1110);
        check("rel_seg", {25'd0, seg}, 32'b1000000);
        exp_q.delete();
        pend_m = 1'b0;
        sync_frame();
        exp_q.push_back(ZERO_SEGS);
        observe(-1, vecs[0], -1, vecs[0]);     // the discarded load must not appear
        observe(-1, vecs[0], -1, vecs[0]);

        // dut2: dwell time, frame period, and leading-zero blanking.
        sync_frame2();
        observe2(1'b1, vecs2[0], vecs2[1].segs);
        observe2(1'b1, vecs2[1], vecs2[0].segs);
        observe2(1'b0, vecs2[0], vecs2[1].segs);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
